// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
`default_nettype none

package spi_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_byte_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop on full frees room for a same-cycle push.
`default_nettype none

module spi_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/spi_txn_sequencer.sv
// Splits a multi-byte SPI command into back-to-back single-byte master transactions,
// feeding MOSI bytes from a TX FIFO and collecting MISO bytes into an RX FIFO.
`default_nettype none

module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [1:0]        i_cmd_cs,
  input  logic              i_cmd_cpol,
  input  logic              i_cmd_cpha,
  input  logic [7:0]        i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [7:0]        o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  input  logic              i_clr_err,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rx_overflow,
  output logic [7:0]        o_mosi_data,
  output logic              o_mosi_valid,
  input  logic              i_mosi_ready,
  input  logic              i_miso_valid,
  input  logic [7:0]        i_miso_data,
  output logic [1:0]        o_cs,
  output logic              o_cpol,
  output logic              o_cpha
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         cs_q, cs_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BYTE_W-1:0]  mosi_data_q, mosi_data_d;
  logic               mosi_valid_q, mosi_valid_d;
  logic               rx_got_q, rx_got_d;
  logic               ovf_q, ovf_d;
  logic               miso_prev_q, miso_prev_d;

  logic [BYTE_W-1:0]  tx_head;
  logic               tx_full, tx_empty, tx_pop;
  logic               rx_full, rx_empty, rx_push, rx_drop, rx_capture;
  logic [CW-1:0]      tx_count, rx_count;
  logic               cmd_accept;
  logic               unused_cnt;

  assign unused_cnt = ^{tx_count, rx_count};

  assign cmd_accept = i_cmd_valid && cmd_ready_q;
  assign tx_pop     = (state_q == S_LOAD) && !tx_empty && i_mosi_ready;
  // Only a fresh MISO strobe during the active byte counts; a level held high is one byte.
  assign rx_capture = i_miso_valid && !miso_prev_q &&
                      ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE));
  assign rx_drop    = rx_capture && rx_full && !i_rx_ready;
  assign rx_push    = rx_capture && !rx_drop;

  spi_byte_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (i_tx_valid),
    .i_push_data (i_tx_data),
    .i_pop       (tx_pop),
    .o_head      (tx_head),
    .o_full      (tx_full),
    .o_empty     (tx_empty),
    .o_count     (tx_count)
  );

  spi_byte_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (rx_push),
    .i_push_data (i_miso_data),
    .i_pop       (i_rx_ready),
    .o_head      (o_rx_data),
    .o_full      (rx_full),
    .o_empty     (rx_empty),
    .o_count     (rx_count)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    cs_d         = cs_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mosi_data_d  = mosi_data_q;
    mosi_valid_d = 1'b0;
    rx_got_d     = rx_got_q || rx_capture;
    miso_prev_d  = i_miso_valid;
    ovf_d        = ovf_q;

    // A new overflow outranks a same-cycle clear.
    if (rx_drop)        ovf_d = 1'b1;
    else if (i_clr_err) ovf_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          rem_d  = i_cmd_len;
          cs_d   = i_cmd_cs;
          cpol_d = i_cmd_cpol;
          cpha_d = i_cmd_cpha;
          if (i_cmd_len != '0) begin
            state_d = S_LOAD;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (tx_pop) begin
          mosi_data_d  = tx_head;
          mosi_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rx_got_d = 1'b0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!i_mosi_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_mosi_ready && rx_got_q) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      cs_q         <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mosi_data_q  <= '0;
      mosi_valid_q <= 1'b0;
      rx_got_q     <= 1'b0;
      ovf_q        <= 1'b0;
      miso_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      cs_q         <= cs_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mosi_data_q  <= mosi_data_d;
      mosi_valid_q <= mosi_valid_d;
      rx_got_q     <= rx_got_d;
      ovf_q        <= ovf_d;
      miso_prev_q  <= miso_prev_d;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_rx_overflow = ovf_q;
  assign o_mosi_data   = mosi_data_q;
  assign o_mosi_valid  = mosi_valid_q;
  assign o_cs          = cs_q;
  assign o_cpol        = cpol_q;
  assign o_cpha        = cpha_q;
  assign o_tx_ready    = !tx_full;
  assign o_rx_valid    = !rx_empty;

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench: byte-level SPI master model echoing ~MOSI, hand-computed expectations.
`default_nettype none

module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_len = '0;
  logic [1:0] cmd_cs = '0;
  logic       cmd_cpol = 1'b0;
  logic       cmd_cpha = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic       busy, done, rx_ovf;
  logic [7:0] mosi_data;
  logic       mosi_valid;
  logic       m_ready = 1'b1;
  logic       m_miso_valid = 1'b0;
  logic [7:0] m_miso_data = '0;
  logic [1:0] cs;
  logic       cpol, cpha;

  always #5 clk = ~clk;

  spi_txn_sequencer #(.FIFO_DEPTH(8), .LEN_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_len(cmd_len),
    .i_cmd_cs(cmd_cs), .i_cmd_cpol(cmd_cpol), .i_cmd_cpha(cmd_cpha),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .i_clr_err(clr_err), .o_busy(busy), .o_done(done), .o_rx_overflow(rx_ovf),
    .o_mosi_data(mosi_data), .o_mosi_valid(mosi_valid), .i_mosi_ready(m_ready),
    .i_miso_valid(m_miso_valid), .i_miso_data(m_miso_data),
    .o_cs(cs), .o_cpol(cpol), .o_cpha(cpha)
  );

  // Master model: busy for 3 cycles, then returns ~MOSI with MISO valid held m_hold cycles.
  int         m_phase = 0;
  int         m_cnt = 0;
  int         m_hold = 1;
  logic [7:0] m_byte = '0;

  always @(posedge clk) begin
    case (m_phase)
      0: if (mosi_valid) begin
        m_ready <= 1'b0; m_byte <= mosi_data; m_cnt <= 0; m_phase <= 1;
      end
      1: if (m_cnt == 2) begin
        m_miso_valid <= 1'b1; m_miso_data <= ~m_byte; m_cnt <= 0; m_phase <= 2;
      end else m_cnt <= m_cnt + 1;
      default: if (m_cnt >= m_hold - 1) begin
        m_miso_valid <= 1'b0; m_ready <= 1'b1; m_phase <= 0;
      end else m_cnt <= m_cnt + 1;
    endcase
  end

  logic [7:0] mosi_log[$];
  int mosi_cnt = 0, done_cnt = 0, mv_dbl = 0, done_dbl = 0;
  logic mv_prev = 1'b0, done_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mosi_valid) begin mosi_log.push_back(mosi_data); mosi_cnt++; end
    if (mosi_valid && mv_prev) mv_dbl++;
    if (done) done_cnt++;
    if (done && done_prev) done_dbl++;
    mv_prev   = mosi_valid;
    done_prev = done;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 300) begin tick(); n++; end
    check("tx_ready_wait", {31'd0, tx_ready}, 1);
    tx_data = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] len, input logic [1:0] c, input logic pol, input logic pha);
    int n = 0;
    while (!cmd_ready && n < 300) begin tick(); n++; end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 1);
    cmd_len = len; cmd_cs = c; cmd_cpol = pol; cmd_cpha = pha; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    if (len != 0) begin
      check("busy_after_accept", {31'd0, busy}, 1);
      check("cmd_ready_low", {31'd0, cmd_ready}, 0);
    end else begin
      check("done_len0", {31'd0, done}, 1);
      check("busy_len0", {31'd0, busy}, 0);
    end
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin tick(); n++; end
    check("done_seen", {31'd0, done_cnt > base}, 1);
    repeat (3) tick();
    check("done_once", done_cnt - base, 1);
    check("busy_after_done", {31'd0, busy}, 0);
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, rx_valid}, 1);
    check(tag, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_ovf"}, {31'd0, rx_ovf}, 0);
    check({tag, "_mosi_valid"}, {31'd0, mosi_valid}, 0);
    check({tag, "_mosi_data"}, {24'd0, mosi_data}, 0);
    check({tag, "_cs_pol_pha"}, {28'd0, cs, cpol, cpha}, 0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready}, 1);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 0);
  endtask

  initial begin
    int b;
    int n;

    // 1: reset, then a two-byte transfer on CS 1
    repeat (3) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();
    check("cmd_ready_after_rst", {31'd0, cmd_ready}, 1);
    push_tx(8'hA5);
    push_tx(8'h3C);
    send_cmd(8'd2, 2'd1, 1'b0, 1'b0);
    check("t1_cs", {30'd0, cs}, 1);
    wait_done(300);
    check("t1_mosi_cnt", mosi_cnt, 2);
    check("t1_mosi0", {24'd0, mosi_log[0]}, 32'hA5);
    check("t1_mosi1", {24'd0, mosi_log[1]}, 32'h3C);
    pop_rx("t1_rx0", 8'h5A);
    pop_rx("t1_rx1", 8'hC3);
    check("t1_rx_empty", {31'd0, rx_valid}, 0);

    // 2: command with empty TX FIFO stalls in LOAD until bytes arrive
    b = mosi_cnt;
    send_cmd(8'd3, 2'd2, 1'b1, 1'b1);
    repeat (20) tick();
    check("t2_stall_no_mosi", mosi_cnt, b);
    check("t2_stall_busy", {31'd0, busy}, 1);
    check("t2_cs_pol_pha", {28'd0, cs, cpol, cpha}, 32'hB);
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    wait_done(300);
    check("t2_mosi_cnt", mosi_cnt, b + 3);
    check("t2_mosi0", {24'd0, mosi_log[b]}, 32'h11);
    check("t2_mosi2", {24'd0, mosi_log[b+2]}, 32'h33);
    pop_rx("t2_rx0", 8'hEE);
    pop_rx("t2_rx1", 8'hDD);
    pop_rx("t2_rx2", 8'hCC);

    // 3: zero-length command
    b = mosi_cnt;
    send_cmd(8'd0, 2'd3, 1'b0, 1'b0);
    tick();
    check("t3_done_cleared", {31'd0, done}, 0);
    repeat (5) tick();
    check("t3_no_mosi", mosi_cnt, b);
    check("t3_busy", {31'd0, busy}, 0);

    // 4: ten bytes without RX pops -> 8 kept, 2 dropped
    b = mosi_cnt;
    for (int i = 0; i < 8; i++) push_tx(8'h40 + 8'(i));
    send_cmd(8'd10, 2'd0, 1'b0, 1'b0);
    push_tx(8'h48);
    push_tx(8'h49);
    wait_done(600);
    check("t4_mosi_cnt", mosi_cnt, b + 10);
    check("t4_ovf_set", {31'd0, rx_ovf}, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t4_ovf_clear", {31'd0, rx_ovf}, 0);
    for (int i = 0; i < 8; i++) pop_rx("t4_rx", ~(8'h40 + 8'(i)));
    check("t4_rx_empty", {31'd0, rx_valid}, 0);

    // 5: MISO valid held for four cycles still yields one RX byte each
    m_hold = 4;
    push_tx(8'h0F);
    push_tx(8'h81);
    send_cmd(8'd2, 2'd1, 1'b0, 1'b1);
    wait_done(300);
    pop_rx("t5_rx0", 8'hF0);
    pop_rx("t5_rx1", 8'h7E);
    check("t5_rx_empty", {31'd0, rx_valid}, 0);
    m_hold = 1;

    // 6: reset during WAIT_DONE of the second of four bytes
    b = mosi_cnt;
    n = done_cnt;
    for (int i = 0; i < 4; i++) push_tx(8'h90 + 8'(i));
    send_cmd(8'd4, 2'd3, 1'b1, 1'b0);
    for (int k = 0; k < 300 && mosi_cnt < b + 2; k++) tick();
    check("t6_second_byte", mosi_cnt, b + 2);
    for (int k = 0; k < 50 && m_ready; k++) tick();
    check("t6_master_busy", {31'd0, m_ready}, 0);
    tick();
    rstn = 1'b0;
    tick();
    check_reset_outputs("t6");
    repeat (2) tick();
    rstn = 1'b1;
    repeat (30) tick();
    check("t6_no_done", done_cnt, n);
    check("t6_no_more_mosi", mosi_cnt, b + 2);
    check("t6_rx_empty", {31'd0, rx_valid}, 0);

    check("mosi_valid_single_cycle", mv_dbl, 0);
    check("done_single_cycle", done_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Upstream feeder for the byte-level SPI master.
- Accepts a host command (byte count, chip select, CPOL/CPHA), streams TX bytes from an internal TX FIFO into the master's MOSI handshake one byte at a time, and collects each returned MISO byte into an internal RX FIFO.
- Sits between the SoC register/bus front-end and the SPI master; turns a multi-byte transfer into back-to-back single-byte master transactions.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of two, at least 2.
- LEN_W, 8, width of the command byte count.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset: synchronous, active-low
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  high in IDLE only
- i_cmd_len  in  LEN_W  number of bytes to transfer; 0 means empty transaction
- i_cmd_cs  in  2  chip-select index
- i_cmd_cpol  in  1  SPI clock polarity
- i_cmd_cpha  in  1  SPI clock phase
- i_tx_data  in  8  TX FIFO push data
- i_tx_valid  in  1  TX FIFO push strobe
- o_tx_ready  out  1  TX FIFO not full
- o_rx_data  out  8  RX FIFO head
- o_rx_valid  out  1  RX FIFO not empty
- i_rx_ready  in  1  RX FIFO pop strobe
- i_clr_err  in  1  clears o_rx_overflow
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle pulse at end of transaction
- o_rx_overflow  out  1  sticky: an RX byte was dropped
- o_mosi_data  out  8  byte to master
- o_mosi_valid  out  1  one-cycle start pulse to master
- i_mosi_ready  in  1  master idle
- i_miso_valid  in  1  master RX byte valid (level; may stay high for several cycles)
- i_miso_data  in  8  master RX byte
- o_cs  out  2  to master chip select
- o_cpol  out  1  to master CPOL
- o_cpha  out  1  to master CPHA

Behaviour:
- Reset values:
  - o_cmd_ready=0, o_busy=0, o_done=0, o_rx_overflow=0, o_mosi_valid=0, o_mosi_data=0.
  - o_cs=0, o_cpol=0, o_cpha=0.
  - Both FIFOs empty, so o_tx_ready=1 and o_rx_valid=0 in the cycle after reset.
  - State = IDLE. o_cmd_ready rises in the first cycle after reset.
- Command acceptance:
  - A command is accepted when i_cmd_valid && o_cmd_ready.
  - On acceptance, register len, cs, cpol and cpha. o_cs, o_cpol and o_cpha hold these values until the next accepted command.
  - o_busy rises on the cycle after acceptance.
- FSM states:
  - IDLE: on accept, go to LOAD if len != 0. If len == 0, pulse o_done on the next cycle and stay in IDLE.
  - LOAD: wait until the TX FIFO is non-empty and i_mosi_ready = 1. Then pop one TX byte into o_mosi_data and go to ISSUE. Stalls indefinitely while the TX FIFO is empty.
  - ISSUE: o_mosi_valid = 1 for exactly one cycle; clear rx_got; go to WAIT_BUSY.
  - WAIT_BUSY: wait for i_mosi_ready = 0 (master has started), then go to WAIT_DONE.
  - WAIT_DONE: wait until i_mosi_ready = 1 and rx_got = 1. Then decrement the remaining count. If remaining is 0, pulse o_done, drop o_busy and go to IDLE; otherwise go to LOAD.
- RX capture:
  - Capture on the rising edge of i_miso_valid (registered previous value) only while in WAIT_BUSY or WAIT_DONE; set rx_got.
  - Push i_miso_data into the RX FIFO. If the RX FIFO is full, drop the byte and set o_rx_overflow; the transaction still completes.
  - o_rx_overflow stays set until i_clr_err = 1. If i_clr_err and a new overflow occur in the same cycle, the set wins.
- Minimum gap between master bytes: 2 cycles (WAIT_DONE → LOAD → ISSUE).
- FIFOs:
  - Simultaneous push and pop on a full or empty FIFO is legal: a pop on full frees space for the push; a push on empty is popped next cycle, with no bypass.
  - A push while full is ignored. A pop while empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Host may push TX bytes in any state, including before the command.
- Reset mid-transaction:
  - Returns everything to reset values on the next edge, and the FIFOs are flushed.
  - A master byte already in flight is abandoned; no o_done is produced.

Decomposition:
- Package spi_seq_pkg:
  - State encoding constants S_IDLE, S_LOAD, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE.
  - Byte width constant 8.
- Sub-module spi_byte_fifo (parameters WIDTH, DEPTH):
  - Synchronous FIFO with push, pop, full, empty and count.
  - Instantiated twice, once for TX and once for RX.

Test Plan:
1. Reset, push 0xA5, 0x3C; command len=2, cs=1, cpol=0, cpha=0 with a master model echoing ~MOSI -> two o_mosi_valid pulses with data 0xA5 then 0x3C; o_cs=1; RX FIFO holds 0x5A, 0xC3; o_done is a single pulse; o_busy low afterwards.
2. Command len=3 with the TX FIFO empty; push bytes 20 cycles later -> FSM holds in LOAD with o_mosi_valid=0 until the first push, then completes 3 bytes and pulses o_done once.
3. Command len=0 -> o_done pulses one cycle after acceptance; o_mosi_valid is never asserted; o_busy stays 0.
4. FIFO_DEPTH=8, command len=10 with i_rx_ready=0 -> RX FIFO holds the first 8 bytes, 2 bytes are dropped, o_rx_overflow=1; i_clr_err for one cycle -> o_rx_overflow=0.
5. Master model holds i_miso_valid high for 4 cycles per byte -> exactly one RX push per byte.
6. Assert i_rstn=0 during WAIT_DONE of byte 2 of 4 -> next cycle all outputs are at reset values, both FIFOs are empty, and no o_done is produced.
